// File: rtl/vga_pkg.sv
// Shared raster constants and count type for the vga_if pipeline (1024x768@60 defaults).
package vga_pkg;

    localparam int unsigned COUNT_W = 11;
    typedef logic [COUNT_W-1:0] count_t;
    typedef logic [11:0]        rgb_t;

    localparam int unsigned H_ACTIVE = 1024;
    localparam int unsigned H_FP     = 24;
    localparam int unsigned H_SYNC   = 136;
    localparam int unsigned H_BP     = 160;

    localparam int unsigned V_ACTIVE = 768;
    localparam int unsigned V_FP     = 3;
    localparam int unsigned V_SYNC   = 6;
    localparam int unsigned V_BP     = 29;

    localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
    localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;

endpackage

// File: rtl/vga_if.sv
// Raster bundle passed stage to stage: counters, sync/blank flags and pixel colour.
interface vga_if;
    import vga_pkg::*;

    count_t hcount;
    count_t vcount;
    logic   hsync;
    logic   vsync;
    logic   hblnk;
    logic   vblnk;
    rgb_t   rgb;

    modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface

// File: rtl/vga_timing_gen.sv
// Raster source: free-running h/v counters with registered sync/blank flags and frame_start strobe.
// Define VGA_SYNC_NEG_POL_EN for active-low hsync/vsync (reset level 1); default is active-high.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int unsigned H_FP     = vga_pkg::H_FP,
    parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
    parameter int unsigned H_BP     = vga_pkg::H_BP,
    parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int unsigned V_FP     = vga_pkg::V_FP,
    parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
    parameter int unsigned V_BP     = vga_pkg::V_BP
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    vga_if.master  vga_out,
    output logic   frame_start
);
    import vga_pkg::*;

    localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SS  = H_ACTIVE + H_FP;
    localparam int unsigned H_SE  = H_SS + H_SYNC;
    localparam int unsigned V_SS  = V_ACTIVE + V_FP;
    localparam int unsigned V_SE  = V_SS + V_SYNC;

    if (H_TOT > (1 << COUNT_W) - 1 || V_TOT > (1 << COUNT_W) - 1) begin : g_param_check
        $error("vga_timing_gen: raster totals do not fit the count width");
    end

`ifdef VGA_SYNC_NEG_POL_EN
    localparam logic SYNC_ON = 1'b0;
`else
    localparam logic SYNC_ON = 1'b1;
`endif

    count_t r_hcount;
    count_t r_vcount;
    logic   r_hsync;
    logic   r_vsync;
    logic   r_hblnk;
    logic   r_vblnk;
    rgb_t   r_rgb;
    logic   r_frame_start;

    logic   w_h_last;
    logic   w_v_last;
    count_t w_h_next;
    count_t w_v_next;
    logic   w_hsync_next;
    logic   w_vsync_next;
    logic   w_hblnk_next;
    logic   w_vblnk_next;
    logic   w_origin_next;

    // Flags are derived from the next counter values so they register alongside them.
    always_comb begin
        w_h_last = (r_hcount == count_t'(H_TOT - 1));
        w_v_last = (r_vcount == count_t'(V_TOT - 1));
        w_h_next = w_h_last ? '0 : r_hcount + count_t'(1);
        w_v_next = r_vcount;
        if (w_h_last) begin
            w_v_next = w_v_last ? '0 : r_vcount + count_t'(1);
        end
        w_hblnk_next  = (w_h_next >= count_t'(H_ACTIVE));
        w_vblnk_next  = (w_v_next >= count_t'(V_ACTIVE));
        w_hsync_next  = ((w_h_next >= count_t'(H_SS)) && (w_h_next < count_t'(H_SE))) ? SYNC_ON : ~SYNC_ON;
        w_vsync_next  = ((w_v_next >= count_t'(V_SS)) && (w_v_next < count_t'(V_SE))) ? SYNC_ON : ~SYNC_ON;
        w_origin_next = (w_h_next == '0) && (w_v_next == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_hsync       <= ~SYNC_ON;
            r_vsync       <= ~SYNC_ON;
            r_hblnk       <= 1'b0;
            r_vblnk       <= 1'b0;
            r_rgb         <= '0;
            r_frame_start <= 1'b0;
        end else if (en) begin
            r_hcount      <= w_h_next;
            r_vcount      <= w_v_next;
            r_hsync       <= w_hsync_next;
            r_vsync       <= w_vsync_next;
            r_hblnk       <= w_hblnk_next;
            r_vblnk       <= w_vblnk_next;
            r_frame_start <= w_origin_next;
        end else begin
            r_frame_start <= 1'b0;
        end
    end

    assign vga_out.hcount = r_hcount;
    assign vga_out.vcount = r_vcount;
    assign vga_out.hsync  = r_hsync;
    assign vga_out.vsync  = r_vsync;
    assign vga_out.hblnk  = r_hblnk;
    assign vga_out.vblnk  = r_vblnk;
    assign vga_out.rgb    = r_rgb;
    assign frame_start    = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size instance plus a shrunken-raster instance for frame-level wraps.
module tb_vga_timing_gen;

    localparam int unsigned SH_A = 16, SH_FP = 2, SH_S = 4, SH_BP = 3;
    localparam int unsigned SV_A = 8,  SV_FP = 1, SV_S = 2, SV_BP = 3;
    localparam int unsigned SH_T = SH_A + SH_FP + SH_S + SH_BP;
    localparam int unsigned SV_T = SV_A + SV_FP + SV_S + SV_BP;
    localparam int unsigned FH_T = 1344, FV_T = 806;

`ifdef VGA_SYNC_NEG_POL_EN
    localparam logic ACT = 1'b0;
`else
    localparam logic ACT = 1'b1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic fs_full, fs_small;

    always #5 clk = ~clk;

    vga_if if_full ();
    vga_if if_small ();

    vga_timing_gen u_full (
        .clk(clk), .rst(rst), .en(en), .vga_out(if_full), .frame_start(fs_full)
    );

    vga_timing_gen #(
        .H_ACTIVE(SH_A), .H_FP(SH_FP), .H_SYNC(SH_S), .H_BP(SH_BP),
        .V_ACTIVE(SV_A), .V_FP(SV_FP), .V_SYNC(SV_S), .V_BP(SV_BP)
    ) u_small (
        .clk(clk), .rst(rst), .en(en), .vga_out(if_small), .frame_start(fs_small)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Model: raster position is the count of enabled edges since reset, modulo the frame size.
    int unsigned p_full = 0, p_small = 0;
    bit          efs_full = 0, efs_small = 0;
    bit          model_valid = 0;

    always @(posedge clk) begin
        if (rst) begin
            p_full = 0; p_small = 0; efs_full = 0; efs_small = 0; model_valid = 1;
        end else if (en) begin
            p_full   = (p_full + 1) % (FH_T * FV_T);
            p_small  = (p_small + 1) % (SH_T * SV_T);
            efs_full  = (p_full == 0);
            efs_small = (p_small == 0);
        end else begin
            efs_full = 0; efs_small = 0;
        end
    end

    function automatic logic [38:0] model_out(input int unsigned p, input int unsigned ha, input int unsigned hfp,
                                              input int unsigned hs, input int unsigned ht, input int unsigned va,
                                              input int unsigned vfp, input int unsigned vs, input bit fs);
        int unsigned h = p % ht;
        int unsigned v = p / ht;
        logic [10:0] hh = 11'(h);
        logic [10:0] vv = 11'(v);
        logic hsy = (h >= ha + hfp && h < ha + hfp + hs) ? ACT : ~ACT;
        logic vsy = (v >= va + vfp && v < va + vfp + vs) ? ACT : ~ACT;
        return {hh, vv, hsy, vsy, logic'(h >= ha), logic'(v >= va), 12'h000, logic'(fs)};
    endfunction

    always @(negedge clk) begin
        if (model_valid) begin
            check("full_raster",
                  {25'd0, if_full.hcount, if_full.vcount, if_full.hsync, if_full.vsync,
                   if_full.hblnk, if_full.vblnk, if_full.rgb, fs_full},
                  {25'd0, model_out(p_full, 1024, 24, 136, FH_T, 768, 3, 6, efs_full)});
            check("small_raster",
                  {25'd0, if_small.hcount, if_small.vcount, if_small.hsync, if_small.vsync,
                   if_small.hblnk, if_small.vblnk, if_small.rgb, fs_small},
                  {25'd0, model_out(p_small, SH_A, SH_FP, SH_S, SH_T, SV_A, SV_FP, SV_S, efs_small)});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int unsigned n, cnt, first_h, vs_min, vs_max, vb_h, vb_v, fs_hi;
    bit          seen;

    initial begin
        // Reset state
        rst = 1'b1; en = 1'b0;
        step(); step();
        rst = 1'b0;
        check("rst_hcount", 64'(if_full.hcount), 64'd0);
        check("rst_vcount", 64'(if_full.vcount), 64'd0);
        check("rst_sync", {62'd0, if_full.hsync, if_full.vsync}, {62'd0, ~ACT, ~ACT});
        check("rst_blnk_fs", {61'd0, if_full.hblnk, if_full.vblnk, fs_full}, 64'd0);

        // First enabled edge after release
        en = 1'b1;
        step();
        check("first_hcount", 64'(if_full.hcount), 64'd1);
        check("first_vcount", 64'(if_full.vcount), 64'd0);
        check("first_flags", {61'd0, if_full.hblnk, if_full.vblnk, fs_full}, 64'd0);

        // hblnk edge and hsync window on the full-size raster
        repeat (1022) step();
        check("h1023_hcount", 64'(if_full.hcount), 64'd1023);
        check("h1023_hblnk", 64'(if_full.hblnk), 64'd0);
        step();
        check("h1024_hblnk", 64'(if_full.hblnk), 64'd1);
        cnt = 0; first_h = 0;
        repeat (319) begin
            step();
            if (if_full.hsync === ACT) begin
                if (cnt == 0) first_h = if_full.hcount;
                cnt++;
            end
        end
        check("line_end_hcount", 64'(if_full.hcount), 64'd1343);
        check("hsync_first", 64'(first_h), 64'd1048);
        check("hsync_width", 64'(cnt), 64'd136);
        step();
        check("line_wrap", {32'(if_full.hcount), 32'(if_full.vcount)}, {32'd0, 32'd1});

        // Frame wrap, strobe spacing and vertical flags on the shrunken raster
        rst = 1'b1; step(); rst = 1'b0;
        repeat (SH_T * SV_T - 1) step();
        check("pre_wrap_pos", {32'(if_small.hcount), 32'(if_small.vcount)}, {32'(SH_T - 1), 32'(SV_T - 1)});
        check("pre_wrap_fs", 64'(fs_small), 64'd0);
        step();
        check("wrap_pos", {32'(if_small.hcount), 32'(if_small.vcount)}, 64'd0);
        check("wrap_fs", 64'(fs_small), 64'd1);
        step();
        check("post_wrap_fs", 64'(fs_small), 64'd0);
        n = 1; vs_min = 999; vs_max = 0; seen = 0; vb_h = 999; vb_v = 999;
        while (fs_small !== 1'b1 && n < 1000) begin
            if (if_small.vsync === ACT) begin
                if (if_small.vcount < vs_min) vs_min = if_small.vcount;
                if (if_small.vcount > vs_max) vs_max = if_small.vcount;
            end
            if (!seen && if_small.vblnk === 1'b1) begin
                seen = 1; vb_h = if_small.hcount; vb_v = if_small.vcount;
            end
            step();
            n++;
        end
        check("strobe_period", 64'(n), 64'(SH_T * SV_T));
        check("vsync_lines", {32'(vs_min), 32'(vs_max)}, {32'(SV_A + SV_FP), 32'(SV_A + SV_FP + SV_S - 1)});
        check("vblnk_rise", {32'(vb_h), 32'(vb_v)}, {32'd0, 32'(SV_A)});

        // Alternating enable: half-rate advance, strobe stays one clock across a wrap
        rst = 1'b1; en = 1'b0; step(); rst = 1'b0;
        fs_hi = 0;
        for (int i = 0; i < 400; i++) begin
            en = 1'b1; step();
            if (fs_small === 1'b1) fs_hi++;
            en = 1'b0; step();
            if (fs_small === 1'b1) fs_hi++;
        end
        check("alt_full_pos", {32'(if_full.hcount), 32'(if_full.vcount)}, {32'd400, 32'd0});
        check("alt_small_pos", {32'(if_small.hcount), 32'(if_small.vcount)}, {32'd0, 32'd2});
        check("alt_fs_cycles", 64'(fs_hi), 64'd1);

        // Mid-frame reset with en low, then first enabled edge
        rst = 1'b1; en = 1'b1; step(); rst = 1'b0;
        repeat (FH_T + 700) step();
        check("mid_pos", {32'(if_full.hcount), 32'(if_full.vcount)}, {32'd700, 32'd1});
        rst = 1'b1; en = 1'b0; step();
        check("mid_rst_pos", {32'(if_full.hcount), 32'(if_full.vcount)}, 64'd0);
        check("mid_rst_sync", {62'd0, if_full.hsync, if_full.vsync}, {62'd0, ~ACT, ~ACT});
        check("mid_rst_fs", {62'd0, fs_full, fs_small}, 64'd0);
        rst = 1'b0; en = 1'b1; step();
        check("mid_release_pos", {32'(if_full.hcount), 32'(if_full.vcount)}, {32'd1, 32'd0});
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
